regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file. Next generation of the MIPS single-write, dual-read register file.
- Adds the following over that block:
  - configurable data width, depth, read-port count and write-port count;
  - optional write-to-read bypass;
  - optional hardwired zero register;
  - deterministic write-port priority;
  - asynchronous clear.
- Sits in the decode stage. Feeds the ALU operand muxes. Written by the writeback stage, one write port per retiring lane.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = read of an address being written this cycle returns the write data; 0 = returns the stored value.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all writes on the rising edge.
- rst_n  in  1  asynchronous active-low reset; clears every register to 0.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses, packed as rd_addr.
- wr_data  in  NUM_WR*DATA_W  write data, packed as rd_data.
- wr_conflict  out  1  high when two enabled write ports target the same writable address this cycle.

Behaviour:
- Storage:
  - 2**ADDR_W entries of DATA_W bits.
  - rst_n low clears all entries to 0 immediately, independent of clk. Writes are blocked while rst_n is low.
- Reset outputs:
  - rd_data = 0 on all ports, since all entries are 0.
  - wr_conflict follows its inputs; it is gated low while rst_n = 0.
- Writes:
  - On a rising clk edge with rst_n high, each port j with wr_en[j] = 1 stores wr_data[j] at wr_addr[j].
  - Write latency 1 cycle: the value is visible through storage from the next cycle.
- Write conflict:
  - Condition: NUM_WR = 2, both enables high, equal addresses, and the address is writable.
  - The higher-index port wins; the entry gets wr_data[1].
  - wr_conflict = 1 combinationally during that cycle.
  - wr_conflict is constant 0 when NUM_WR = 1.
- Zero register (ZERO_REG = 1):
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including via the bypass path.
  - A conflict on address 0 does not raise wr_conflict.
- Reads:
  - Combinational, zero-cycle latency.
  - rd_data[i] = storage[rd_addr[i]] unless bypass applies.
- Bypass (BYPASS = 1):
  - Applies when some enabled write port has wr_addr equal to rd_addr[i] and the address is not zero-hardwired.
  - rd_data[i] returns that port's wr_data in the same cycle, before the edge.
  - When two ports match, the higher-index port's data is returned, consistent with write priority.
  - Bypass is gated by rst_n: while rst_n = 0, rd_data is 0.
- Reads during writes (BYPASS = 0): the old stored value is returned until the edge.
- Multiple read ports may address the same entry; each returns an identical value.
- Reset mid-operation:
  - Asserting rst_n between edges clears storage at once.
  - A write presented in the same cycle as reset deassertion takes effect only on the first edge with rst_n already high.
- No X propagation: every rd_data bit is defined from reset onward.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, rd_addr = 1, 2 -> rd_data = 0, 0; wr_en = 1 to addr 3 with data 0xAA during reset -> reg 3 reads 0 after release.
- Basic write/read: write addr 1 = 9, next cycle read rd_addr[0] = 1, rd_addr[1] = 1 -> both return 9; before the edge with BYPASS = 0 -> both return 0.
- Bypass: BYPASS = 1, same cycle wr_en = 1, addr 5, data 0x1234, rd_addr[0] = 5 -> rd_data[0] = 0x1234 before the edge; reg 5 holds 0x1234 afterwards.
- Zero register: write addr 0 = 0xFFFFFFFF with BYPASS = 1, read addr 0 -> 0 in the write cycle and in the next; wr_conflict = 0 when both ports target 0.
- Write conflict: NUM_WR = 2, port0 addr 7 data 0x11, port1 addr 7 data 0x22 -> wr_conflict = 1 that cycle; reg 7 reads 0x22; non-conflicting dual write (addrs 8, 9) -> both stored, wr_conflict = 0.
- Async reset mid-run: regs 1–4 loaded, pull rst_n low mid-cycle (between edges) -> all reads 0 immediately; release and write addr 2 = 5 -> only reg 2 nonzero.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   DATA_W-bit entries, 2**ADDR_W deep, NUM_RD combinational read ports,
//   NUM_WR write ports with higher-index priority, optional same-cycle
//   write-to-read bypass, optional hardwired zero register, async clear.
// Ports:
//   clk          rising-edge write clock
//   rst_n        asynchronous active-low clear of all entries
//   rd_addr      packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      packed read data, port i at [i*DATA_W +: DATA_W]
//   wr_en        per-port write enables
//   wr_addr      packed write addresses
//   wr_data      packed write data
//   wr_conflict  two enabled write ports hit the same writable address
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   output logic                       wr_conflict
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic [ADDR_W-1:0] ra;
   logic [DATA_W-1:0] rv;

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Ports are applied in ascending order so the higher index wins.
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
         mem_d[k] = mem_q[k];
      end
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && writable(wr_addr[j*ADDR_W +: ADDR_W])) begin
            mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            mem_q[k] <= mem_d[k];
         end
      end
   end

   // Reads: storage, then bypass (last matching port wins), then zero/reset gating.
   always_comb begin
      rd_data = '0;
      ra      = '0;
      rv      = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra = rd_addr[i*ADDR_W +: ADDR_W];
         rv = mem_q[ra];
         if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                  rv = wr_data[j*DATA_W +: DATA_W];
               end
            end
         end
         if (!writable(ra) || !rst_n) begin
            rv = '0;
         end
         rd_data[i*DATA_W +: DATA_W] = rv;
      end
   end

   generate
      if (NUM_WR == 2) begin : g_conf
         assign wr_conflict = rst_n && wr_en[0] && wr_en[1]
                              && (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W])
                              && writable(wr_addr[0 +: ADDR_W]);
      end else begin : g_noconf
         assign wr_conflict = 1'b0;
      end
   endgenerate

endmodule
